// File: rtl/iq_acq_buffer.sv
// Acquisition buffer: scales and saturates interleaved I/Q words from the decimator,
// packs each pair as {Q,I} into a circular FIFO and drains it through a read-enable port.
module iq_acq_buffer #(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [IN_WIDTH-1:0]   datain,
    input  logic                  in_valid,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   acq_len,
    input  logic [4:0]            shift,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  empty,
    output logic                  full,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [4:0] SHIFT_MAX = 5'(IN_WIDTH - 16);
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(32767);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-32768);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_I,
        S_WAIT_Q,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     acq_len_q, acq_len_d;
    logic [4:0]              shift_q, shift_d;
    logic [ADDR_WIDTH:0]     pair_cnt_q, pair_cnt_d;
    logic [15:0]             i_hold_q, i_hold_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic [31:0]             mem [DEPTH];
    logic signed [IN_WIDTH-1:0] shifted;
    logic [15:0]             sample;
    logic                    empty_w, full_w, rd_fire, wr_en;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_CNT);
    assign rd_fire = rd_en && !empty_w && !start;

    always_comb begin
        shifted = $signed(datain) >>> shift_q;
        if (shifted > SAT_MAX) begin
            sample = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            sample = 16'h8000;
        end else begin
            sample = shifted[15:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acq_len_d  = acq_len_q;
        shift_d    = shift_q;
        pair_cnt_d = pair_cnt_q;
        i_hold_d   = i_hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = done_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;

        if (start) begin
            acq_len_d  = acq_len;
            shift_d    = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
            pair_cnt_d = '0;
            i_hold_d   = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            done_d     = (acq_len == '0);
            state_d    = (acq_len == '0) ? S_DONE : S_WAIT_I;
        end else begin
            unique case (state_q)
                S_WAIT_I: begin
                    if (in_valid) begin
                        i_hold_d = sample;
                        state_d  = S_WAIT_Q;
                    end
                end
                S_WAIT_Q: begin
                    if (in_valid) begin
                        // A read in the same cycle frees a slot, so a full FIFO still accepts the pair
                        if (!full_w || rd_fire) begin
                            wr_en = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        pair_cnt_d = pair_cnt_q + CNT_ONE;
                        if (pair_cnt_d == acq_len_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_I;
                        end
                    end
                end
                default: ;
            endcase

            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            unique case ({wr_en, rd_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: ;
            endcase
        end

        busy_d = (state_d == S_WAIT_I) || (state_d == S_WAIT_Q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acq_len_q  <= '0;
            shift_q    <= '0;
            pair_cnt_q <= '0;
            i_hold_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            acq_len_q  <= acq_len_d;
            shift_q    <= shift_d;
            pair_cnt_q <= pair_cnt_d;
            i_hold_q   <= i_hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {sample, i_hold_q};
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign word_count = count_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_iq_acq_buffer.sv
// Bench for iq_acq_buffer: directed and random traffic against a queue-based reference model;
// expected read words go to a scoreboard drained by an independent rd_valid monitor.
module tb_iq_acq_buffer;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int SHMAX = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [31:0]   datain = '0;
    logic          in_valid = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   acq_len = '0;
    logic [4:0]    shift = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   word_count;
    logic          empty, full, busy, done, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // Reference model state
    logic [31:0] m_fifo[$];
    bit          m_active, m_expect_i, m_done, m_ovf;
    int          m_len, m_shift, m_pairs;
    logic [15:0] m_ihold;

    iq_acq_buffer #(.IN_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESET(RESET), .datain(datain), .in_valid(in_valid),
        .start(start), .acq_len(acq_len), .shift(shift), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .word_count(word_count),
        .empty(empty), .full(full), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] proc(logic [31:0] d, int sh);
        longint x;
        x = longint'($signed(d));
        x = x >>> sh;
        if (x > 32767)  return 16'h7FFF;
        if (x < -32768) return 16'h8000;
        return x[15:0];
    endfunction

    function automatic void m_reset();
        m_fifo.delete();
        m_active = 0; m_expect_i = 1; m_done = 0; m_ovf = 0;
        m_len = 0; m_shift = 0; m_pairs = 0; m_ihold = '0;
    endfunction

    function automatic void model_step(bit st, bit v, logic [31:0] d, int len, int sh, bit rd);
        if (st) begin
            m_fifo.delete();
            m_len = len; m_shift = (sh > SHMAX) ? SHMAX : sh;
            m_pairs = 0; m_ovf = 0; m_ihold = '0;
            m_done = (len == 0); m_active = (len != 0); m_expect_i = 1;
            return;
        end
        if (rd && m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
        if (m_active && v) begin
            if (m_expect_i) begin
                m_ihold = proc(d, m_shift);
                m_expect_i = 0;
            end else begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back({proc(d, m_shift), m_ihold});
                else m_ovf = 1;
                m_pairs++;
                m_expect_i = 1;
                if (m_pairs == m_len) begin
                    m_active = 0;
                    m_done = 1;
                end
            end
        end
    endfunction

    // Scoreboard monitor
    always @(posedge CLK) begin
        #1;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_data %0h expected no read at %0t", rd_data, $time);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input bit st, input bit v, input logic [31:0] d, input int len, input int sh, input bit rd);
        @(negedge CLK);
        start = st; in_valid = v; datain = d; acq_len = len[AW:0]; shift = sh[4:0]; rd_en = rd;
        model_step(st, v, d, len, sh, rd);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    task automatic pair(input logic [31:0] i_w, input logic [31:0] q_w, input bit rd);
        cyc(0, 1, i_w, 0, 0, rd);
        cyc(0, 1, q_w, 0, 0, rd);
    endtask

    task automatic chk_status();
        check("word_count", word_count, m_fifo.size());
        check("empty", empty, m_fifo.size() == 0);
        check("full", full, m_fifo.size() == DEPTH);
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
    endtask

    task automatic chk_reset();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_word_count", word_count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 1);
        idle(1);
    endtask

    initial begin
        logic [31:0] d;
        m_reset();
        #3 chk_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Basic capture
        cyc(1, 0, '0, 2, 0, 0);
        check("busy_after_start", busy, 1);
        pair(32'd5, 32'hFFFF_FFFD, 0);
        pair(32'd100, 32'd7, 0);
        check("done_after_last_q", done, 1);
        check("busy_after_last_q", busy, 0);
        chk_status();
        cyc(0, 0, '0, 0, 0, 1);
        check("rd_valid_latency", rd_valid, 1);
        cyc(0, 0, '0, 0, 0, 1);
        idle(1);
        check("rd_valid_drop", rd_valid, 0);
        chk_status();

        // Scaling and saturation, including a clamped shift
        cyc(1, 0, '0, 2, 4, 0);
        pair(32'h0001_2340, 32'hFFFF_0000, 0);
        pair(32'h8000_0000, 32'h0000_7FF0, 0);
        chk_status();
        drain(2);
        cyc(1, 0, '0, 1, 0, 0);
        pair(32'h7FFF_FFFF, 32'hFFFF_8000, 0);
        drain(1);
        cyc(1, 0, '0, 2, 31, 0);
        pair(32'h7FFF_FFFF, 32'h8000_0000, 0);
        pair(32'h0123_4567, 32'hFFFE_0000, 0);
        drain(2);

        // Overflow: more pairs than slots, no reads
        cyc(1, 0, '0, 11, 0, 0);
        for (int i = 0; i < 11; i++) pair(32'(i), 32'(-i), 0);
        idle(1);
        chk_status();
        drain(DEPTH + 1);
        chk_status();

        // Simultaneous write and read every cycle
        cyc(1, 0, '0, 8, 2, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 32'($urandom), 0, 0, 1);
            check("wc_le1", word_count <= 1, 1);
            cyc(0, 1, 32'($urandom), 0, 0, 1);
            check("wc_le1", word_count <= 1, 1);
        end
        drain(2);
        chk_status();

        // Full FIFO with a read in the same cycle as the Q word
        cyc(1, 0, '0, 10, 0, 0);
        for (int i = 0; i < 8; i++) pair(32'(i + 40), 32'(i + 80), 0);
        cyc(0, 1, 32'd1000, 0, 0, 0);
        cyc(0, 1, 32'd2000, 0, 0, 1);
        chk_status();
        drain(DEPTH + 1);

        // Restart while in WAIT_Q with 3 words stored; start wins over in_valid and rd_en
        cyc(1, 0, '0, 6, 0, 0);
        for (int i = 0; i < 3; i++) pair(32'(i + 7), 32'(i + 9), 0);
        cyc(0, 1, 32'd55, 0, 0, 0);
        chk_status();
        cyc(1, 1, 32'd66, 2, 0, 1);
        check("rd_valid_after_start", rd_valid, 0);
        chk_status();
        pair(32'd11, 32'd22, 0);
        chk_status();
        drain(2);

        // acq_len = 0 and in_valid while done/idle
        cyc(1, 0, '0, 0, 0, 0);
        check("len0_busy", busy, 0);
        check("len0_done", done, 1);
        pair(32'd3, 32'd4, 0);
        check("len0_busy2", busy, 0);
        chk_status();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit st, v, rd;
            st = ($urandom_range(39) == 0);
            v  = ($urandom_range(9) < 7);
            rd = ($urandom_range(9) < 4);
            case ($urandom_range(3))
                0: d = 32'($signed($urandom_range(65535)) - 32768);
                1: d = {$urandom_range(1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
                default: d = $urandom;
            endcase
            cyc(st, v, d, $urandom_range(12), $urandom_range(31), rd);
            chk_status();
        end
        drain(DEPTH + 1);

        // Async reset mid-acquisition
        cyc(1, 0, '0, 5, 0, 0);
        pair(32'd1, 32'd2, 0);
        pair(32'd3, 32'd4, 0);
        #2 RESET = 1'b1;
        #1 chk_reset();
        m_reset();
        @(negedge CLK);
        RESET = 1'b0;
        pair(32'd9, 32'd9, 0);
        chk_status();

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
